// File: rtl/piso_pkg.sv
// Shared types and parameter defaults for the parallel-in / serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int WIDTH_DEF     = 8;
  localparam bit MSB_FIRST_DEF = 1'b1;
  localparam bit IDLE_BIT_DEF  = 1'b0;

  // Bit counter width; a 1-bit floor keeps the vector legal for tiny words.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial stream bundle between a word source and the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = piso_pkg::WIDTH_DEF
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             serial_out;
  logic             serial_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output load_data, load_valid, shift_en,
    input  load_ready, serial_out, serial_valid, word_done, busy
  );

  modport slave (
    input  load_data, load_valid, shift_en,
    output load_ready, serial_out, serial_valid, word_done, busy
  );

endinterface

// File: rtl/bit_counter.sv
// Position counter for the word in the shifter; flags the last bit at WIDTH-1.
module bit_counter #(
  parameter  int WIDTH = piso_pkg::WIDTH_DEF,
  localparam int CW    = piso_pkg::cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          rollover_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign rollover_o = (cnt_q == CW'(WIDTH - 1));
  assign count_o    = cnt_q;

  // Saturating at WIDTH-1 keeps the count in range even if clear is missed.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !rollover_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Word serializer with one pending slot so back-to-back words stream without a gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF,
  parameter bit IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  piso_serializer_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             word_done_q, word_done_d;

  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             xfer;
  logic             advance;
  logic [WIDTH-1:0] shifted;
  logic             head_bit;

  assign xfer    = bus.load_valid && !pend_full_q;
  assign advance = (state_q == SHIFT) && bus.shift_en;
  assign shifted = MSB_FIRST ? (shifter_q << 1) : (shifter_q >> 1);

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (advance && last_bit),
    .en_i      (advance),
    .count_o   (bit_cnt),
    .rollover_o(last_bit)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    shifter_d   = shifter_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    word_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          shifter_d = bus.load_data;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (advance && last_bit) begin
          word_done_d = 1'b1;
          if (pend_full_q) begin
            shifter_d   = pend_q;
            pend_full_d = 1'b0;
          end else if (xfer) begin
            shifter_d = bus.load_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (advance) begin
            shifter_d = shifted;
          end
          if (xfer) begin
            pend_d      = bus.load_data;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every register samples the pre-edge values of its peers.
    if (rst) begin
      state_q     <= IDLE;
      shifter_q   <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shifter_q   <= shifter_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      word_done_q <= word_done_d;
    end
  end

  assign head_bit         = MSB_FIRST ? shifter_q[WIDTH-1] : shifter_q[0];
  assign bus.serial_out   = (state_q == SHIFT) ? head_bit : IDLE_BIT;
  assign bus.serial_valid = (state_q == SHIFT);
  assign bus.busy         = (state_q == SHIFT) || pend_full_q;
  assign bus.load_ready   = !pend_full_q;
  assign bus.word_done    = word_done_q;

  a_cnt_range : assert property (@(posedge clk) disable iff (rst) bit_cnt <= CW'(WIDTH - 1));

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer at WIDTH=4, MSB first, idle level 0.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   wd_count;
  logic wd_pend;
  logic [3:0] hist;
  logic match_seen;
  exp_t sb[$];

  piso_serializer_if #(.WIDTH(4)) bus ();

  piso_serializer #(
    .WIDTH    (4),
    .MSB_FIRST(1'b1),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the word's bits, then hold load_valid until a transfer edge passes.
  task automatic load_word(input logic [3:0] w, output int waits);
    logic r;
    r = 1'b0;
    for (int i = 3; i >= 0; i--) sb.push_back('{b: w[i], last: (i == 0)});
    bus.load_data  = w;
    bus.load_valid = 1'b1;
    waits = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      r = bus.load_ready;
      @(posedge clk);
      #1;
      if (r) break;
      waits++;
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic run_len(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.serial_valid) return;
      n++;
    end
  endtask

  // Monitor: a bit is consumed when serial_valid and shift_en are both high before an edge.
  always @(negedge clk) begin
    exp_t e;
    check("word_done_timing", 32'(bus.word_done), 32'(wd_pend));
    wd_pend = 1'b0;
    if (bus.word_done) wd_count++;
    if (bus.serial_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_bit", 32'(sb.size()), 32'd1);
      end else begin
        check("serial_bit", 32'(bus.serial_out), 32'(sb[0].b));
        if (bus.shift_en) begin
          e          = sb.pop_front();
          wd_pend    = e.last;
          hist       = {hist[2:0], bus.serial_out};
          if (hist == 4'b1101) match_seen = 1'b1;
        end
      end
    end else begin
      check("idle_level", 32'(bus.serial_out), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    int w0, w1, w2, n, wd0;
    total          = 0;
    bad            = 0;
    wd_count       = 0;
    wd_pend        = 1'b0;
    hist           = 4'b0000;
    match_seen     = 1'b0;
    rst            = 1'b1;
    bus.load_data  = '0;
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_serial_out", 32'(bus.serial_out), 32'd0);
    check("rst_serial_valid", 32'(bus.serial_valid), 32'd0);
    check("rst_word_done", 32'(bus.word_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_load_ready", 32'(bus.load_ready), 32'd1);

    // Single word 1101, continuous shifting.
    bus.shift_en = 1'b1;
    wd0 = wd_count;
    load_word(4'b1101, w0);
    check("t1_waits", 32'(w0), 32'd0);
    check("t1_first_valid", 32'(bus.serial_valid), 32'd1);
    check("t1_first_bit", 32'(bus.serial_out), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    run_len(n);
    check("t1_run_len", 32'(n), 32'd4);
    tick();
    check("t1_word_done_count", 32'(wd_count - wd0), 32'd1);
    check("t1_detector_match", 32'(match_seen), 32'd1);

    // Back-to-back 1010 then 0110 through the pending slot.
    wd0 = wd_count;
    load_word(4'b1010, w0);
    load_word(4'b0110, w1);
    check("t2_waits", 32'(w0 + w1), 32'd0);
    check("t2_ready_low_pend_full", 32'(bus.load_ready), 32'd0);
    check("t2_busy", 32'(bus.busy), 32'd1);
    run_len(n);
    check("t2_run_len_no_gap", 32'(n), 32'd7);
    tick();
    check("t2_word_done_count", 32'(wd_count - wd0), 32'd2);
    check("t2_ready_after", 32'(bus.load_ready), 32'd1);

    // 1001 with shift_en pattern 1,0,0 repeating: four advances over ten cycles.
    bus.shift_en = 1'b0;
    wd0 = wd_count;
    load_word(4'b1001, w0);
    for (int k = 0; k < 10; k++) begin
      bus.shift_en = (k % 3 == 0);
      @(negedge clk);
      check("t3_valid_hold", 32'(bus.serial_valid), 32'd1);
      tick();
    end
    bus.shift_en = 1'b1;
    @(negedge clk);
    check("t3_idle_after", 32'(bus.serial_valid), 32'd0);
    tick();
    check("t3_word_done_count", 32'(wd_count - wd0), 32'd1);

    // Pending full: 1111 is refused until the pending word enters the shifter.
    wd0 = wd_count;
    load_word(4'b1010, w0);
    load_word(4'b0110, w1);
    load_word(4'b1111, w2);
    check("t4_refused_cycles", 32'(w2), 32'd3);
    check("t4_ready_low_again", 32'(bus.load_ready), 32'd0);
    run_len(n);
    check("t4_run_len", 32'(n), 32'd7);
    tick();
    check("t4_word_done_count", 32'(wd_count - wd0), 32'd3);

    // Reset after two bits of 1100 with the pending slot occupied.
    wd0 = wd_count;
    load_word(4'b1100, w0);
    load_word(4'b0101, w1);
    tick();
    rst = 1'b1;
    tick();
    sb.delete();
    rst = 1'b0;
    check("t5_serial_out", 32'(bus.serial_out), 32'd0);
    check("t5_serial_valid", 32'(bus.serial_valid), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_load_ready", 32'(bus.load_ready), 32'd1);
    check("t5_word_done", 32'(bus.word_done), 32'd0);
    repeat (4) tick();
    check("t5_no_word_done", 32'(wd_count - wd0), 32'd0);

    // 0011 transferred on the same edge as the last bit of 0101, pending empty.
    wd0 = wd_count;
    load_word(4'b0101, w0);
    repeat (3) tick();
    load_word(4'b0011, w1);
    check("t6_waits", 32'(w0 + w1), 32'd0);
    check("t6_valid_no_gap", 32'(bus.serial_valid), 32'd1);
    check("t6_first_bit", 32'(bus.serial_out), 32'd0);
    check("t6_pend_empty", 32'(bus.load_ready), 32'd1);
    run_len(n);
    check("t6_run_len", 32'(n), 32'd4);
    tick();
    check("t6_word_done_count", 32'(wd_count - wd0), 32'd2);

    repeat (2) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 Parameter: IDLE_BIT, default 0, value driven on serial_out when no word is shifting.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: load_data  input  WIDTH  parallel word to serialize.
REQ-008 Port: load_valid  input  1  load_data is valid.
REQ-009 Port: load_ready  output  1  block can accept a word this cycle.
REQ-010 Port: shift_en  input  1  bit-rate tick; one bit advances per cycle in which it is high.
REQ-011 Port: serial_out  output  1  serial bit stream; feeds a downstream pattern detector's data input.
REQ-012 Port: serial_valid  output  1  serial_out carries a word bit.
REQ-013 Port: word_done  output  1  one-cycle pulse after the last bit of a word is consumed.
REQ-014 Port: busy  output  1  shifter loaded or pending word held.

Function
REQ-015 Storage: one shift register (shifter) plus one pending register (pend) with flag pend_full.
REQ-016 FSM states: IDLE (shifter empty) and SHIFT (shifter holds a word); no other states reachable.
REQ-017 load_ready = !pend_full, combinational from registers only; a transfer is load_valid && load_ready on a rising edge.
REQ-018 Transfer in IDLE: word loads directly into shifter, bit_cnt = 0, state -> SHIFT next cycle; pend untouched.
REQ-019 Transfer in SHIFT: word loads into pend, pend_full = 1.
REQ-020 In SHIFT with shift_en = 1 and bit_cnt < WIDTH-1: shifter shifts one position toward the output end, bit_cnt increments.
REQ-021 In SHIFT with shift_en = 1 and bit_cnt = WIDTH-1 (last bit): word_done = 1 next cycle; if pend_full, pend moves into shifter, pend_full = 0, bit_cnt = 0, stay SHIFT (zero-gap); else state -> IDLE.
REQ-022 Simultaneous last-bit shift and transfer with pend empty: incoming word loads directly into shifter, stay SHIFT, pend_full stays 0.
REQ-023 Simultaneous last-bit shift and transfer are impossible with pend full (load_ready = 0).
REQ-024 shift_en = 0: shifter, bit_cnt, and state hold; serial_out stable.
REQ-025 shift_en in IDLE: ignored.
REQ-026 serial_out = shifter[WIDTH-1] if MSB_FIRST else shifter[0] in SHIFT; IDLE_BIT in IDLE; registered-source only, no input-to-output path.
REQ-027 serial_valid = (state == SHIFT); busy = (state == SHIFT) || pend_full.
REQ-028 Latency: word accepted in IDLE at edge N drives its first bit on serial_out in cycle N+1.
REQ-029 bit_cnt width = clog2(WIDTH); never exceeds WIDTH-1.

Reset
REQ-030 rst sampled high at a rising edge -> state = IDLE, bit_cnt = 0, pend_full = 0, shifter = 0, pend = 0 at that edge, overriding all other inputs.
REQ-031 Reset output values: serial_out = IDLE_BIT, serial_valid = 0, word_done = 0, busy = 0, load_ready = 1.
REQ-032 Reset mid-word: partial word and pending word discarded, no word_done pulse.

Structure
REQ-033 Shared package piso_pkg: state enum typedef (IDLE, SHIFT) and parameter defaults.
REQ-034 One sub-module, bit_counter: synchronous clear, enable, and rollover flag at WIDTH-1; instantiated once.

Verification (WIDTH=4, MSB_FIRST=1, IDLE_BIT=0)
REQ-035 Load 4'b1101, shift_en held high -> serial_out 1,1,0,1 on four consecutive cycles; word_done pulses on the following cycle; a downstream 1101 detector asserts its match output.
REQ-036 Load 4'b1010, then 4'b0110 while the first word is shifting -> serial_out 1,0,1,0,0,1,1,0 with no gap; word_done pulses twice; load_ready is low while pend is full.
REQ-037 Load 4'b1001, shift_en toggling 1,0,0,1,... -> each bit holds through low cycles; serial_valid stays high throughout; exactly 4 advances.
REQ-038 Pend full and shifter busy, load_valid held with 4'b1111 -> no transfer until the last-bit shift; load_ready rises the cycle after pend empties.
REQ-039 rst asserted after 2 bits of 4'b1100 with pend full -> next cycle serial_out = 0, serial_valid = 0, busy = 0, load_ready = 1, no word_done.
REQ-040 Last-bit shift coincident with a transfer of 4'b0011 and pend empty -> next bits 0,0,1,1 with no IDLE cycle.
